// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates the icache fill port and the dcache read/write port
// onto a single-ported RAM, and turns the RAM handshake (ramstate) into
// per-requester wait strobes.
//
// Dcache has priority by default. Defining ARB_IFAIR_EN adds the IFAIR_LIMIT
// parameter and a 4-bit fairness counter. When iREN has been pending across
// IFAIR_LIMIT dcache completions, the icache is granted next.
//
// Ports:
//   CLK, nRST            clock (rising edge), async active-low reset
//   iREN/iaddr           icache read request and word address
//   iwait/iload          icache stall (low on the completing cycle) / data
//   dREN/dWEN/daddr      dcache read/write request and word address
//   dstore               dcache write data
//   dwait/dload          dcache stall (low on the completing cycle) / data
//   ramREN/ramWEN        RAM read/write enables
//   ramaddr/ramstore     RAM address / write data (0 when not granted)
//   ramload/ramstate     RAM read data / handshake (FREE,BUSY,ACCESS,ERROR)
//   ram_err              sticky flag, set by ERROR during a granted access
module mem_arbiter
`ifdef ARB_IFAIR_EN
#(
    parameter int unsigned IFAIR_LIMIT = 4
)
`endif
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        ram_err
);

    localparam int unsigned DATA_W = 32;
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t state_q, state_d;
    logic   ram_err_q, ram_err_d;
    logic   d_req;
    logic   fair_force;

    assign d_req   = dREN | dWEN;
    assign iload   = ramload;
    assign dload   = ramload;
    assign ram_err = ram_err_q;

`ifdef ARB_IFAIR_EN
    localparam int unsigned CNT_W = 4;

    logic [CNT_W-1:0] fair_cnt_q, fair_cnt_d;
    logic             i_done, d_done;

    assign i_done     = (state_q == GNT_I) && iREN && (ramstate == RAM_ACCESS);
    assign d_done     = (state_q == GNT_D) && d_req && (ramstate == RAM_ACCESS);
    assign fair_force = iREN && (fair_cnt_q >= CNT_W'(IFAIR_LIMIT));

    // Count dcache wins while the icache waits; saturates so it cannot wrap.
    always_comb begin
        fair_cnt_d = fair_cnt_q;
        if (i_done) begin
            fair_cnt_d = '0;
        end else if (d_done && iREN && (fair_cnt_q != {CNT_W{1'b1}})) begin
            fair_cnt_d = fair_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fair_cnt_q <= '0;
        end else begin
            fair_cnt_q <= fair_cnt_d;
        end
    end
`else
    assign fair_force = 1'b0;
`endif

    // State register and sticky error flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            ram_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ram_err_q <= ram_err_d;
        end
    end

    // Next state and RAM/wait outputs. A completion always returns to IDLE,
    // which gives the cache one cycle to drop or retarget its request.
    always_comb begin
        state_d   = state_q;
        ram_err_d = ram_err_q;
        iwait     = 1'b1;
        dwait     = 1'b1;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;

        case (state_q)
            IDLE: begin
                if (fair_force) begin
                    state_d = GNT_I;
                end else if (d_req) begin
                    state_d = GNT_D;
                end else if (iREN) begin
                    state_d = GNT_I;
                end
            end

            GNT_I: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (!iREN) begin
                    state_d = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    iwait   = 1'b0;
                    state_d = IDLE;
                end else if (ramstate == RAM_ERROR) begin
                    ram_err_d = 1'b1;
                end
            end

            GNT_D: begin
                ramaddr  = daddr;
                ramstore = DATA_W'(dstore);
                // Write wins when both dcache enables are high.
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (!d_req) begin
                    state_d = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    dwait   = 1'b0;
                    state_d = IDLE;
                end else if (ramstate == RAM_ERROR) begin
                    ram_err_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change on the falling edge. Outputs
// are checked 1 ns later, which is well away from the rising (active) edge.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        ram_err;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    int n_total = 0;
    int n_pass  = 0;

    mem_arbiter dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .ram_err  (ram_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Check the idle-looking outputs: both waits high, nothing driven onto the RAM.
    task automatic chk_quiet(input string tag);
        chk({tag, ".iwait"},    32'(iwait),  32'd1);
        chk({tag, ".dwait"},    32'(dwait),  32'd1);
        chk({tag, ".ramREN"},   32'(ramREN), 32'd0);
        chk({tag, ".ramWEN"},   32'(ramWEN), 32'd0);
        chk({tag, ".ramaddr"},  ramaddr,     32'h0);
        chk({tag, ".ramstore"}, ramstore,    32'h0);
    endtask

    initial begin
        int i_done_cnt;
        int d_done_cnt;
        int d_before_first_i;

        nRST = 1'b0; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

        // Reset state
        @(posedge CLK); @(posedge CLK);
        @(negedge CLK); #1;
        chk_quiet("rst");
        chk("rst.ram_err", 32'(ram_err), 32'd0);
        nRST = 1'b1;

        // Reset in the middle of a dcache grant
        @(negedge CLK); dREN = 1'b1; daddr = 32'h10; ramstate = BUSY; #1;
        chk("midrst.idle_ramREN", 32'(ramREN), 32'd0);
        @(negedge CLK); #1;
        chk("midrst.gnt_ramREN", 32'(ramREN), 32'd1);
        chk("midrst.gnt_ramaddr", ramaddr, 32'h10);
        chk("midrst.gnt_dwait", 32'(dwait), 32'd1);
        nRST = 1'b0; #1;
        chk_quiet("midrst.inrst");
        chk("midrst.ram_err", 32'(ram_err), 32'd0);
        @(negedge CLK); dREN = 1'b0; ramstate = FREE; nRST = 1'b1; #1;
        chk_quiet("midrst.after");

        // Icache-only read: two BUSY cycles after the grant, then ACCESS
        @(negedge CLK); iREN = 1'b1; iaddr = 32'h40; ramload = 32'hDEADBEEF; ramstate = BUSY; #1;
        chk("iread.idle_ramREN", 32'(ramREN), 32'd0);
        chk("iread.idle_iwait", 32'(iwait), 32'd1);
        @(negedge CLK); #1;
        chk("iread.g0_ramREN", 32'(ramREN), 32'd1);
        chk("iread.g0_ramaddr", ramaddr, 32'h40);
        chk("iread.g0_iwait", 32'(iwait), 32'd1);
        @(negedge CLK); #1;
        chk("iread.g1_iwait", 32'(iwait), 32'd1);
        chk("iread.g1_ramREN", 32'(ramREN), 32'd1);
        @(negedge CLK); ramstate = ACCESS; #1;
        chk("iread.done_iwait", 32'(iwait), 32'd0);
        chk("iread.done_iload", iload, 32'hDEADBEEF);
        chk("iread.done_dwait", 32'(dwait), 32'd1);
        @(negedge CLK); iREN = 1'b0; ramstate = FREE; #1;
        chk_quiet("iread.bubble");

        // Simultaneous requests: dcache write wins, icache follows the bubble
        @(negedge CLK);
        iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; dWEN = 1'b1;
        daddr = 32'h100; dstore = 32'h12345678; #1;
        chk("sim.idle_ramWEN", 32'(ramWEN), 32'd0);
        @(negedge CLK); ramstate = ACCESS; #1;
        chk("sim.d_ramWEN", 32'(ramWEN), 32'd1);
        chk("sim.d_ramREN", 32'(ramREN), 32'd0);
        chk("sim.d_ramaddr", ramaddr, 32'h100);
        chk("sim.d_ramstore", ramstore, 32'h12345678);
        chk("sim.d_dwait", 32'(dwait), 32'd0);
        chk("sim.d_iwait", 32'(iwait), 32'd1);
        @(negedge CLK); dREN = 1'b0; dWEN = 1'b0; ramstate = FREE; #1;
        chk_quiet("sim.bubble");
        @(negedge CLK); ramstate = ACCESS; #1;
        chk("sim.i_ramREN", 32'(ramREN), 32'd1);
        chk("sim.i_ramaddr", ramaddr, 32'h80);
        chk("sim.i_ramstore", ramstore, 32'h0);
        chk("sim.i_iwait", 32'(iwait), 32'd0);
        @(negedge CLK); iREN = 1'b0; ramstate = FREE; #1;
        chk_quiet("sim.after");

        // Abandon: icache drops its request while the RAM is busy
        @(negedge CLK); iREN = 1'b1; iaddr = 32'h44; ramstate = BUSY; #1;
        @(negedge CLK); #1;
        chk("abn.gnt_ramREN", 32'(ramREN), 32'd1);
        @(negedge CLK); iREN = 1'b0; #1;
        chk("abn.drop_ramREN", 32'(ramREN), 32'd0);
        chk("abn.drop_iwait", 32'(iwait), 32'd1);
        @(negedge CLK); ramstate = ACCESS; #1;
        chk_quiet("abn.idle");
        @(negedge CLK); ramstate = FREE; #1;
        chk_quiet("abn.idle2");

        // Error path: two ERROR cycles, then ACCESS on a dcache read
        @(negedge CLK); dREN = 1'b1; daddr = 32'h200; ramload = 32'hCAFEF00D; #1;
        @(negedge CLK); ramstate = ERROR; #1;
        chk("err.e0_dwait", 32'(dwait), 32'd1);
        chk("err.e0_ramREN", 32'(ramREN), 32'd1);
        chk("err.e0_ram_err", 32'(ram_err), 32'd0);
        @(negedge CLK); #1;
        chk("err.e1_dwait", 32'(dwait), 32'd1);
        chk("err.e1_ram_err", 32'(ram_err), 32'd1);
        @(negedge CLK); ramstate = ACCESS; #1;
        chk("err.acc_dwait", 32'(dwait), 32'd0);
        chk("err.acc_dload", dload, 32'hCAFEF00D);
        chk("err.acc_ramaddr", ramaddr, 32'h200);
        @(negedge CLK); dREN = 1'b0; ramstate = FREE; #1;
        chk_quiet("err.after");
        chk("err.sticky", 32'(ram_err), 32'd1);

        // Fairness under continuous dcache reads with the icache pending
        i_done_cnt = 0; d_done_cnt = 0; d_before_first_i = -1;
        @(negedge CLK); dREN = 1'b1; iREN = 1'b1; ramstate = ACCESS;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (!iwait) begin
                if (i_done_cnt == 0) d_before_first_i = d_done_cnt;
                i_done_cnt++;
            end
            if (!dwait) d_done_cnt++;
            @(negedge CLK);
        end
`ifdef ARB_IFAIR_EN
        chk("fair.i_done", 32'(i_done_cnt), 32'd5);
        chk("fair.d_done", 32'(d_done_cnt), 32'd20);
        chk("fair.d_before_i", 32'(d_before_first_i), 32'd4);
`else
        chk("fair.i_done", 32'(i_done_cnt), 32'd0);
        chk("fair.d_done", 32'(d_done_cnt), 32'd25);
`endif
        dREN = 1'b0; iREN = 1'b0; ramstate = FREE;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
